// File: rtl/hdlc_rx_deframer.sv
// Bit-serial HDLC receive deframer: flag hunt, zero-bit removal, abort detection,
// byte assembly, size count, optional CRC-16 FCS check and overflow detection.
module hdlc_rx_deframer #(
  parameter int MAX_FRAME_BYTES = 128,
  localparam int SIZE_W = $clog2(MAX_FRAME_BYTES + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx,
  input  logic              RxEN,
  input  logic              Rx_FCSen,
  output logic [7:0]        Rx_Data,
  output logic              Rx_NewByte,
  output logic              Rx_ValidFrame,
  output logic              Rx_EoF,
  output logic [SIZE_W-1:0] Rx_FrameSize,
  output logic              Rx_FrameError,
  output logic              Rx_FCSerr,
  output logic              Rx_Overflow,
  output logic              Rx_AbortDetect
);

  typedef enum logic [1:0] {HUNT, OPEN, DATA} state_t;

  localparam logic [SIZE_W-1:0] MAX_SZ   = SIZE_W'(MAX_FRAME_BYTES);
  localparam logic [SIZE_W-1:0] FCS_SZ   = SIZE_W'(2);
  localparam logic [15:0]       CRC_INIT = 16'hFFFF;
  localparam logic [15:0]       CRC_GOOD = 16'hF0B8;
  localparam logic [15:0]       CRC_POLY = 16'h8408;

  state_t            state_q, state_d;
  logic [7:0]        win_q, win_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [2:0]        ones_q, ones_d;
  logic [7:0]        sr_q, sr_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [SIZE_W-1:0] bytes_q, bytes_d;
  logic [15:0]       crc_q, crc_d;
  logic              fcsen_q, fcsen_d;
  logic              ovf_q, ovf_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              ferr_q, ferr_d;
  logic              fcserr_q, fcserr_d;
  logic [7:0]        data_q, data_d;
  logic              newbyte_q, newbyte_d;
  logic              eof_q, eof_d;
  logic              abort_q, abort_d;

  logic [7:0] shift_win;
  logic       is_flag, is_abort, commit, dbit, in_frame;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    wcnt_d    = wcnt_q;
    ones_d    = ones_q;
    sr_d      = sr_q;
    bitcnt_d  = bitcnt_q;
    bytes_d   = bytes_q;
    crc_d     = crc_q;
    fcsen_d   = fcsen_q;
    ovf_d     = ovf_q;
    size_d    = size_q;
    ferr_d    = ferr_q;
    fcserr_d  = fcserr_q;
    data_d    = data_q;
    newbyte_d = 1'b0;
    eof_d     = 1'b0;
    abort_d   = 1'b0;
    shift_win = {Rx, win_q[7:1]};
    is_flag   = 1'b0;
    is_abort  = 1'b0;
    commit    = 1'b0;
    dbit      = win_q[0];
    in_frame  = (state_q == DATA);

    if (RxEN) begin
      win_d    = shift_win;
      wcnt_d   = (wcnt_q == 4'd8) ? 4'd8 : wcnt_q + 4'd1;
      is_flag  = (wcnt_q >= 4'd7) && (shift_win == 8'h7E);
      is_abort = (shift_win[7:1] == 7'h7F);
      commit   = (wcnt_q == 4'd8) && (state_q != HUNT);

      // The bit leaving the window precedes any flag/abort completing now.
      if (commit) begin
        if ((ones_q == 3'd5) && !dbit) begin
          ones_d = 3'd0;
        end else begin
          ones_d = dbit ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
          if (state_q == OPEN) begin
            in_frame = 1'b1;
            state_d  = DATA;
            ovf_d    = 1'b0;
            size_d   = '0;
            ferr_d   = 1'b0;
            fcserr_d = 1'b0;
          end
          sr_d     = {dbit, sr_q[7:1]};
          crc_d    = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ dbit) ? CRC_POLY : 16'h0000);
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (bytes_q == MAX_SZ) begin
              ovf_d = 1'b1;
            end else begin
              bytes_d   = bytes_q + 1'b1;
              newbyte_d = 1'b1;
              data_d    = {dbit, sr_q[7:1]};
            end
          end
        end
      end

      if (is_flag) begin
        fcsen_d = Rx_FCSen;
        state_d = OPEN;
        if (in_frame) begin
          eof_d    = 1'b1;
          ferr_d   = (bitcnt_d != 3'd0) || (fcsen_q && (bytes_d <= FCS_SZ));
          fcserr_d = fcsen_q && (crc_d != CRC_GOOD);
          if (!fcsen_q)
            size_d = bytes_d;
          else if (bytes_d > FCS_SZ)
            size_d = bytes_d - FCS_SZ;
          else
            size_d = '0;
        end
      end

      if (is_abort) begin
        state_d = HUNT;
        abort_d = in_frame;
      end

      // Flag and abort bits never reach the destuffer; start the next frame clean.
      if (is_flag || is_abort) begin
        win_d    = 8'h00;
        wcnt_d   = 4'd0;
        ones_d   = 3'd0;
        sr_d     = 8'h00;
        bitcnt_d = 3'd0;
        bytes_d  = '0;
        crc_d    = CRC_INIT;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= HUNT;
      win_q     <= 8'h00;
      wcnt_q    <= 4'd0;
      ones_q    <= 3'd0;
      sr_q      <= 8'h00;
      bitcnt_q  <= 3'd0;
      bytes_q   <= '0;
      crc_q     <= CRC_INIT;
      fcsen_q   <= 1'b0;
      ovf_q     <= 1'b0;
      size_q    <= '0;
      ferr_q    <= 1'b0;
      fcserr_q  <= 1'b0;
      data_q    <= 8'h00;
      newbyte_q <= 1'b0;
      eof_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      wcnt_q    <= wcnt_d;
      ones_q    <= ones_d;
      sr_q      <= sr_d;
      bitcnt_q  <= bitcnt_d;
      bytes_q   <= bytes_d;
      crc_q     <= crc_d;
      fcsen_q   <= fcsen_d;
      ovf_q     <= ovf_d;
      size_q    <= size_d;
      ferr_q    <= ferr_d;
      fcserr_q  <= fcserr_d;
      data_q    <= data_d;
      newbyte_q <= newbyte_d;
      eof_q     <= eof_d;
      abort_q   <= abort_d;
    end
  end

  assign Rx_Data        = data_q;
  assign Rx_NewByte     = newbyte_q;
  assign Rx_ValidFrame  = (state_q == DATA);
  assign Rx_EoF         = eof_q;
  assign Rx_FrameSize   = size_q;
  assign Rx_FrameError  = ferr_q;
  assign Rx_FCSerr      = fcserr_q;
  assign Rx_Overflow    = ovf_q;
  assign Rx_AbortDetect = abort_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench for hdlc_rx_deframer: a default instance and a MAX_FRAME_BYTES=4 instance.
module tb_hdlc_rx_deframer;

  typedef struct {
    int   size;
    logic ferr;
    logic fcserr;
    logic ovf;
  } st_t;

  logic clk = 1'b0;
  logic rst, rx, en_m, en_s, fcsen;

  logic [7:0] data_m, data_s;
  logic [7:0] size_m;
  logic [2:0] size_s;
  logic nb_m, vf_m, eof_m, ferr_m, fcserr_m, ovf_m, ab_m;
  logic nb_s, vf_s, eof_s, ferr_s, fcserr_s, ovf_s, ab_s;

  int n_cmp = 0;
  int n_bad = 0;
  int en_div = 1;
  int ones_run = 0;
  int exp_abort = 0;
  logic use_small = 1'b0;
  logic [7:0] fr [0:15];

  logic [7:0] qb_m[$];
  logic [7:0] qb_s[$];
  st_t qs_m[$];
  st_t qs_s[$];
  st_t got_m, got_s;

  always #5 clk = ~clk;

  hdlc_rx_deframer #(.MAX_FRAME_BYTES(128)) dut (
    .Clk(clk), .Rst(rst), .Rx(rx), .RxEN(en_m), .Rx_FCSen(fcsen),
    .Rx_Data(data_m), .Rx_NewByte(nb_m), .Rx_ValidFrame(vf_m), .Rx_EoF(eof_m),
    .Rx_FrameSize(size_m), .Rx_FrameError(ferr_m), .Rx_FCSerr(fcserr_m),
    .Rx_Overflow(ovf_m), .Rx_AbortDetect(ab_m)
  );

  hdlc_rx_deframer #(.MAX_FRAME_BYTES(4)) dut_s (
    .Clk(clk), .Rst(rst), .Rx(rx), .RxEN(en_s), .Rx_FCSen(fcsen),
    .Rx_Data(data_s), .Rx_NewByte(nb_s), .Rx_ValidFrame(vf_s), .Rx_EoF(eof_s),
    .Rx_FrameSize(size_s), .Rx_FrameError(ferr_s), .Rx_FCSerr(fcserr_s),
    .Rx_Overflow(ovf_s), .Rx_AbortDetect(ab_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en_m = 1'b0;
      en_s = 1'b0;
    end
  endtask

  task automatic drive_raw(input logic b);
    for (int i = 1; i < en_div; i++) begin
      @(negedge clk);
      en_m = 1'b0;
      en_s = 1'b0;
    end
    @(negedge clk);
    rx   = b;
    en_m = !use_small;
    en_s = use_small;
  endtask

  task automatic send_flag();
    for (int i = 0; i < 8; i++) drive_raw((i == 0 || i == 7) ? 1'b0 : 1'b1);
    ones_run = 0;
  endtask

  task automatic send_dbit(input logic b);
    drive_raw(b);
    if (b) begin
      ones_run++;
      if (ones_run == 5) begin
        drive_raw(1'b0);
        ones_run = 0;
      end
    end else begin
      ones_run = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_dbit(v[i]);
  endtask

  task automatic send_frame(input logic fcs, input logic exp_fcserr, input int nb);
    int  mx;
    st_t s;
    mx = use_small ? 4 : 128;
    fcsen = fcs;
    send_flag();
    for (int i = 0; i < nb; i++) begin
      if (i < mx) begin
        if (use_small) qb_s.push_back(fr[i]);
        else           qb_m.push_back(fr[i]);
      end
      send_byte(fr[i]);
    end
    s.size   = ((nb > mx) ? mx : nb) - (fcs ? 2 : 0);
    s.ferr   = 1'b0;
    s.fcserr = exp_fcserr;
    s.ovf    = (nb > mx);
    if (use_small) qs_s.push_back(s);
    else           qs_m.push_back(s);
    send_flag();
    idle(3);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (nb_m) begin
        if (qb_m.size() == 0) check_eq("unexpected_byte_m", 1, 0);
        else                  check_eq("byte_m", data_m, qb_m.pop_front());
        if (!eof_m) check_eq("valid_at_byte_m", vf_m, 1);
      end
      if (eof_m) begin
        check_eq("valid_at_eof_m", vf_m, 0);
        if (qs_m.size() == 0) begin
          check_eq("unexpected_eof_m", 1, 0);
        end else begin
          got_m = qs_m.pop_front();
          check_eq("size_m", size_m, got_m.size);
          check_eq("ferr_m", ferr_m, got_m.ferr);
          check_eq("fcserr_m", fcserr_m, got_m.fcserr);
          check_eq("ovf_m", ovf_m, got_m.ovf);
        end
      end
      if (ab_m) begin
        check_eq("abort_expected_m", (exp_abort > 0), 1);
        if (exp_abort > 0) exp_abort--;
        check_eq("valid_at_abort_m", vf_m, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (nb_s) begin
        if (qb_s.size() == 0) check_eq("unexpected_byte_s", 1, 0);
        else                  check_eq("byte_s", data_s, qb_s.pop_front());
        check_eq("ovf_before_limit_s", ovf_s, 0);
      end
      if (eof_s) begin
        if (qs_s.size() == 0) begin
          check_eq("unexpected_eof_s", 1, 0);
        end else begin
          got_s = qs_s.pop_front();
          check_eq("size_s", size_s, got_s.size);
          check_eq("ferr_s", ferr_s, got_s.ferr);
          check_eq("ovf_s", ovf_s, got_s.ovf);
        end
      end
      if (ab_s) check_eq("unexpected_abort_s", 1, 0);
    end
  end

  initial begin
    st_t s;
    rst = 1'b1; rx = 1'b1; en_m = 1'b0; en_s = 1'b0; fcsen = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check_eq("rst_data", data_m, 0);
    check_eq("rst_newbyte", nb_m, 0);
    check_eq("rst_valid", vf_m, 0);
    check_eq("rst_eof", eof_m, 0);
    check_eq("rst_size", size_m, 0);
    check_eq("rst_ferr", ferr_m, 0);
    check_eq("rst_fcserr", fcserr_m, 0);
    check_eq("rst_ovf", ovf_m, 0);
    check_eq("rst_abort", ab_m, 0);

    fr[0] = 8'hA5; fr[1] = 8'h3C;
    send_frame(1'b0, 1'b0, 2);

    fr[0] = 8'hFF;
    send_frame(1'b0, 1'b0, 1);
    en_div = 3;
    send_frame(1'b0, 1'b0, 1);
    en_div = 1;

    for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
    fr[9] = 8'h6E; fr[10] = 8'h90;
    send_frame(1'b1, 1'b0, 11);
    fr[0] = 8'h30;
    send_frame(1'b1, 1'b1, 11);

    fcsen = 1'b0;
    send_flag();
    send_byte(8'h55);
    exp_abort++;
    for (int i = 0; i < 7; i++) drive_raw(1'b1);
    ones_run = 0;
    idle(3);
    check_eq("valid_after_abort", vf_m, 0);
    fr[0] = 8'h11;
    send_frame(1'b0, 1'b0, 1);

    send_flag();
    qb_m.push_back(8'h12);
    send_byte(8'h12);
    send_dbit(1'b1); send_dbit(1'b0); send_dbit(1'b1); send_dbit(1'b1); send_dbit(1'b0);
    s.size = 1; s.ferr = 1'b1; s.fcserr = 1'b0; s.ovf = 1'b0;
    qs_m.push_back(s);
    send_flag();
    idle(3);

    send_flag();
    send_byte(8'hA5);
    send_dbit(1'b1); send_dbit(1'b0); send_dbit(1'b0); send_dbit(1'b1);
    idle(1);
    check_eq("valid_mid_frame", vf_m, 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    ones_run = 0;
    idle(1);
    check_eq("midrst_valid", vf_m, 0);
    check_eq("midrst_data", data_m, 0);
    check_eq("midrst_size", size_m, 0);
    check_eq("midrst_eof", eof_m, 0);
    check_eq("midrst_newbyte", nb_m, 0);
    fr[0] = 8'h42;
    send_frame(1'b0, 1'b0, 1);

    use_small = 1'b1;
    for (int i = 0; i < 6; i++) fr[i] = 8'h01 + 8'(i);
    send_frame(1'b0, 1'b0, 6);
    use_small = 1'b0;

    idle(20);
    check_eq("bytes_left_m", qb_m.size(), 0);
    check_eq("status_left_m", qs_m.size(), 0);
    check_eq("bytes_left_s", qb_s.size(), 0);
    check_eq("status_left_s", qs_s.size(), 0);
    check_eq("aborts_left", exp_abort, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_deframer.md
# hdlc_rx_deframer

Parametrised bit-serial HDLC receive deframer that sits between the serial line input and the Rx frame buffer. It does flag hunting, zero-bit removal, abort detection, byte assembly, frame-size counting, an optional CRC-16 FCS check and overflow detection against a configurable maximum frame length. It produces per-byte write strobes and per-frame status.

## Interface
- MAX_FRAME_BYTES, 128: maximum destuffed bytes per frame, FCS included; range 4..255.
- SIZE_W, $clog2(MAX_FRAME_BYTES+1): localparam; width of the size counter and Rx_FrameSize.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Rx  in  1  serial line bit; sampled only when RxEN=1.
- RxEN  in  1  bit-enable; one raw bit is consumed per cycle with RxEN=1.
- Rx_FCSen  in  1  1 = last 2 bytes are CRC-16 FCS, checked and excluded from size; sampled at the opening flag.
- Rx_Data  out  8  last assembled byte; first-received bit in the LSB.
- Rx_NewByte  out  1  1-cycle strobe, Rx_Data valid.
- Rx_ValidFrame  out  1  high while a frame is in progress (DATA state).
- Rx_EoF  out  1  1-cycle strobe at closing flag; status below valid.
- Rx_FrameSize  out  SIZE_W  bytes in frame (minus 2 if FCS enabled).
- Rx_FrameError  out  1  frame length not a byte multiple, or FCSen frame ≤2 bytes.
- Rx_FCSerr  out  1  FCS residue mismatch.
- Rx_Overflow  out  1  frame exceeded MAX_FRAME_BYTES.
- Rx_AbortDetect  out  1  1-cycle strobe on abort inside a frame.

## Operation
- 8-bit raw window: a raw bit is *committed* when 8 further enabled bits have arrived after it. Window == 0x7E means flag; 7 consecutive ones in the window means abort. Bits forming a flag or abort are never committed.
- Destuffing on committed bits: after five consecutive committed ones, a following 0 is discarded and the ones count clears.
- States:
  - HUNT: waiting for a flag. Flag → OPEN.
  - OPEN: flag seen, no data committed yet. First committed data bit → DATA. A flag here keeps OPEN; back-to-back flags are idle and produce no EoF.
  - DATA: assemble bytes and update the FCS and the count.
    - Flag → EoF, then OPEN. The closing flag also opens the next frame. Flags do not share zeros.
    - Abort → Rx_AbortDetect, then HUNT.
- FCS: CRC-16-CCITT, x^16+x^12+x^5+1, LSB-first, init 0xFFFF, run over all destuffed bits including the FCS. Good residue is 0xF0B8. Rx_FCSerr=0 whenever FCSen=0.
- Overflow: on the byte that would be number MAX_FRAME_BYTES+1, set Rx_Overflow and suppress all further Rx_NewByte. Rx_FrameSize saturates at MAX_FRAME_BYTES. EoF still fires.
- Status outputs (size, error, FCSerr, overflow):
  - Rx_Overflow is raised mid-frame, as above.
  - Size, error and FCSerr update in the EoF cycle.
  - All four hold until the first data bit of the next frame, where they clear.
- Abort outside DATA: no strobe.

## Timing
- Reset: all outputs 0, state HUNT, window cleared, CRC 0xFFFF. Rst mid-frame discards the frame with no EoF or abort strobe.
- Rx_NewByte and Rx_Data are registered, high the cycle after the enabled cycle that commits the 8th destuffed bit.
- Rx_EoF and Rx_AbortDetect are high the cycle after the enabled cycle that completes the flag or the 7th one.
- RxEN=0: state, window and counters hold; all strobes 0.
- Rx_ValidFrame: set with the first committed data bit, clears in the same cycle as the EoF or abort strobe.
- Strobes never overlap. Rx_NewByte can immediately precede Rx_EoF by 8 enabled bits (the closing flag length).

## Test plan
- FCSen=0, line 7E A5 3C 7E, RxEN=1 continuously → NewByte twice with Rx_Data A5 then 3C; EoF; FrameSize=2; FrameError=0.
- Stuffing: data byte 0xFF sent as bits 11111 0 111 between flags → Rx_Data=FF, FrameSize=1. Also vary RxEN 1-of-3 cycles → identical results.
- FCSen=1, ASCII "123456789" plus FCS bytes 6E 90 → FrameSize=9, FCSerr=0. Flip one data bit → FCSerr=1.
- Abort: flag, 0x55, then seven 1s → AbortDetect pulse, ValidFrame=0, no EoF. A following flag + 0x11 + flag → normal frame, size 1.
- MAX_FRAME_BYTES=4, FCSen=0, 6-byte frame → exactly 4 NewByte; Overflow=1 from byte 5; EoF with FrameSize=4.
- 13 data bits between flags → EoF with FrameError=1. Rst asserted mid-frame → all outputs 0, no EoF.
